// File: rtl/bnn_weight_loader_pkg.sv
// Shared types and constants for the BNN weight loader: FSM encoding,
// default frame length and nibble/index widths.
package bnn_weight_loader_pkg;

    localparam int unsigned NUM_NEURONS_DEFAULT = 12;
    localparam int unsigned NIB_W               = 4;
    localparam int unsigned IDX_W               = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_e;

endpackage

// File: rtl/bnn_byte_fifo.sv
// Small power-of-two byte FIFO; push is ignored when full and pop when empty,
// and the head entry is read combinationally from registered storage.
module bnn_byte_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bnn_weight_loader.sv
// Streams a frame of weight bytes into a BNN weight port as low/high nibble
// pairs, one neuron per pair, with a small byte buffer on the input side.
import bnn_weight_loader_pkg::*;

module bnn_weight_loader #(
    parameter int unsigned NUM_NEURONS = NUM_NEURONS_DEFAULT,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    output logic             load_en,
    output logic [NIB_W-1:0] nib_out,
    output logic [IDX_W-1:0] neuron_idx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned       CW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0]  NN   = IDX_W'(NUM_NEURONS);
    localparam logic [IDX_W-1:0]  LAST = IDX_W'(NUM_NEURONS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             push, pop;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [7:0]       fifo_head;

    bnn_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (s_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign neuron_idx = idx_q;

    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        idx_d     = idx_q;
        pop       = 1'b0;
        load_en   = 1'b0;
        nib_out   = '0;
        done      = 1'b0;
        busy      = (state_q != ST_IDLE);
        s_ready   = (state_q == ST_WAIT || state_q == ST_LOW || state_q == ST_HIGH)
                    && !fifo_full && (acc_cnt_q < NN);
        push      = s_valid && s_ready;
        if (push) begin
            acc_cnt_d = acc_cnt_q + IDX_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_WAIT;
                    acc_cnt_d = '0;
                    idx_d     = '0;
                end
            end
            ST_WAIT: begin
                if (!fifo_empty) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                load_en = 1'b1;
                nib_out = fifo_head[NIB_W-1:0];
                state_d = ST_HIGH;
            end
            ST_HIGH: begin
                load_en = 1'b1;
                nib_out = fifo_head[2*NIB_W-1:NIB_W];
                pop     = 1'b1;
                if (idx_q < NN) begin
                    idx_d = idx_q + IDX_W'(1);
                end
                // A byte pushed in the same cycle as the pop keeps the pair stream gapless.
                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                end else if (fifo_count > CW'(1) || push) begin
                    state_d = ST_LOW;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_cnt_q <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_cnt_q <= acc_cnt_d;
            idx_q     <= idx_d;
        end
    end

endmodule

// File: tb/tb_bnn_weight_loader.sv
// Scoreboard bench for bnn_weight_loader: accepted bytes queue expected nibble
// events, observed load_en strobes are queued and compared per scenario.
module tb_bnn_weight_loader;
    import bnn_weight_loader_pkg::*;

    localparam int N = 12;

    logic       clk = 1'b0;
    logic       reset, start, s_valid, s_ready, load_en, busy, done;
    logic [7:0] s_data;
    logic [3:0] nib_out;
    logic [4:0] neuron_idx;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct packed {
        int         cyc;
        logic [4:0] idx;
        logic [3:0] nib;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  acc_n, done_n, done_cyc, rdy_err;
    bit  rst_hit;

    bnn_weight_loader #(
        .NUM_NEURONS (N),
        .FIFO_DEPTH  (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .load_en    (load_en),
        .nib_out    (nib_out),
        .neuron_idx (neuron_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] byte_at(input int i);
        return 8'(32'hA0 + i * 32'hA1);
    endfunction

    // Sample at the falling edge, record handshakes/strobes, return just after the rising edge.
    task automatic tick(input bit rst3);
        ev_t e;
        @(negedge clk);
        if (s_ready && acc_n >= N) rdy_err++;
        if (s_valid && s_ready) begin
            e.cyc = cyc + 2; e.idx = 5'(acc_n); e.nib = s_data[3:0];
            exp_q.push_back(e);
            e.cyc = cyc + 3; e.nib = s_data[7:4];
            exp_q.push_back(e);
            acc_n++;
        end
        if (load_en) begin
            if (rst3 && neuron_idx == 5'd3 && (obs_q.size() % 2) == 0) begin
                reset   = 1'b1;
                rst_hit = 1'b1;
            end
            e.cyc = cyc; e.idx = neuron_idx; e.nib = nib_out;
            obs_q.push_back(e);
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        tick(0);
        tick(0);
        reset = 1'b0;
    endtask

    task automatic run_frame(input int gap, input bit hold, input int start_at,
                             input bit rst3, input int tail);
        int left;
        exp_q.delete(); obs_q.delete();
        acc_n = 0; done_n = 0; done_cyc = -1; rdy_err = 0; rst_hit = 0;
        left = tail;
        start = 1'b1; s_valid = 1'b0;
        tick(0);
        start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            s_data  = byte_at(acc_n);
            s_valid = (gap == 0) ? (hold || acc_n < N) : (acc_n < N && (k % gap) == 0);
            start   = (k == start_at);
            tick(rst3);
            if (rst_hit) break;
            if (done_n > 0) begin
                if (left == 0) break;
                left--;
            end
        end
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; s_valid = 1'b1; s_data = 8'h5A;
        tick(0);
        @(negedge clk);
        tests++;
        if ({s_ready, load_en, nib_out, neuron_idx, busy, done} !== 13'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {s_ready, load_en, nib_out, neuron_idx, busy, done});
        end
        tests++;
        if (dut.state_q !== ST_IDLE || dut.u_fifo.count !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: state %0d fifo count %0d, expected IDLE and 0",
                     dut.state_q, dut.u_fifo.count);
        end
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; s_valid = 1'b0;
        tick(0);
    endtask

    task automatic test_back_to_back();
        reset_dut();
        run_frame(0, 0, -1, 0, 2);
        tests++;
        if (obs_q.size() != 2 * N || exp_q.size() != 2 * N) begin
            fails++;
            $display("FAIL b2b_count: got %0d strobes, %0d accepted bytes, expected %0d and %0d",
                     obs_q.size(), acc_n, 2 * N, N);
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k].idx !== exp_q[k].idx || obs_q[k].nib !== exp_q[k].nib
                || obs_q[k].cyc !== obs_q[0].cyc + k) begin
                fails++;
                $display("FAIL b2b_event%0d: got idx %0d nib %h cyc %0d, expected idx %0d nib %h cyc %0d",
                         k, obs_q[k].idx, obs_q[k].nib, obs_q[k].cyc,
                         exp_q[k].idx, exp_q[k].nib, obs_q[0].cyc + k);
            end
        end
        tests++;
        if (done_n != 1 || obs_q.size() == 0 || done_cyc != obs_q[obs_q.size()-1].cyc + 1) begin
            fails++;
            $display("FAIL b2b_done: got %0d pulses at cyc %0d, expected 1 right after last strobe",
                     done_n, done_cyc);
        end
        tests++;
        if (neuron_idx !== 5'd12 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: got idx %0d busy %b, expected 12 and 0", neuron_idx, busy);
        end
    endtask

    task automatic test_throttled();
        reset_dut();
        run_frame(5, 0, -1, 0, 2);
        tests++;
        if (obs_q.size() != 2 * N || exp_q.size() != 2 * N) begin
            fails++;
            $display("FAIL thr_count: got %0d strobes %0d accepts, expected %0d and %0d",
                     obs_q.size(), acc_n, 2 * N, N);
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k] !== exp_q[k]) begin
                fails++;
                $display("FAIL thr_event%0d: got idx %0d nib %h cyc %0d, expected idx %0d nib %h cyc %0d",
                         k, obs_q[k].idx, obs_q[k].nib, obs_q[k].cyc,
                         exp_q[k].idx, exp_q[k].nib, exp_q[k].cyc);
            end
        end
        tests++;
        if (neuron_idx !== 5'd12 || done_n != 1) begin
            fails++;
            $display("FAIL thr_end: got idx %0d done pulses %0d, expected 12 and 1",
                     neuron_idx, done_n);
        end
    endtask

    task automatic test_excess();
        reset_dut();
        run_frame(0, 1, -1, 0, 6);
        tests++;
        if (acc_n != N || rdy_err != 0) begin
            fails++;
            $display("FAIL excess_accept: got %0d accepts %0d ready-after-full cycles, expected %0d and 0",
                     acc_n, rdy_err, N);
        end
        tests++;
        if (done_n != 1 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL excess_done: got %0d done pulses s_ready %b, expected 1 and 0",
                     done_n, s_ready);
        end
    endtask

    task automatic test_start_busy();
        reset_dut();
        run_frame(0, 0, 4, 0, 2);
        tests++;
        if (obs_q.size() != 2 * N || acc_n != N || done_n != 1) begin
            fails++;
            $display("FAIL sbusy_count: got %0d strobes %0d accepts %0d done, expected %0d %0d 1",
                     obs_q.size(), acc_n, done_n, 2 * N, N);
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k].idx !== exp_q[k].idx || obs_q[k].nib !== exp_q[k].nib
                || obs_q[k].cyc !== obs_q[0].cyc + k) begin
                fails++;
                $display("FAIL sbusy_event%0d: got idx %0d nib %h, expected idx %0d nib %h",
                         k, obs_q[k].idx, obs_q[k].nib, exp_q[k].idx, exp_q[k].nib);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        run_frame(0, 0, -1, 1, 0);
        @(negedge clk);
        tests++;
        if (!rst_hit || obs_q.size() != 7) begin
            fails++;
            $display("FAIL rmid_trigger: got hit %b with %0d strobes, expected 1 with 7",
                     rst_hit, obs_q.size());
        end
        tests++;
        if ({s_ready, load_en, nib_out, neuron_idx, busy, done} !== 13'b0
            || dut.state_q !== ST_IDLE || dut.u_fifo.count !== 2'd0) begin
            fails++;
            $display("FAIL rmid_clear: got outs %b state %0d fifo %0d, expected 0 IDLE 0",
                     {s_ready, load_en, nib_out, neuron_idx, busy, done},
                     dut.state_q, dut.u_fifo.count);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        tick(0);
        run_frame(0, 0, -1, 0, 1);
        tests++;
        if (obs_q.size() != 2 * N || done_n != 1 || neuron_idx !== 5'd12) begin
            fails++;
            $display("FAIL rmid_reload: got %0d strobes %0d done idx %0d, expected %0d 1 12",
                     obs_q.size(), done_n, neuron_idx, 2 * N);
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            tests++;
            if (obs_q[k].idx !== exp_q[k].idx || obs_q[k].nib !== exp_q[k].nib) begin
                fails++;
                $display("FAIL rmid_event%0d: got idx %0d nib %h, expected idx %0d nib %h",
                         k, obs_q[k].idx, obs_q[k].nib, exp_q[k].idx, exp_q[k].nib);
            end
        end
    endtask

    task automatic test_stall();
        int bad;
        reset_dut();
        bad = 0;
        start = 1'b1; s_valid = 1'b0;
        tick(0);
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || load_en !== 1'b0 || s_ready !== 1'b1 || dut.state_q !== ST_WAIT)
                bad++;
            @(posedge clk); #1;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stall_wait: got %0d bad cycles of 50, expected 0", bad);
        end
        reset_dut();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        acc_n = 0; done_n = 0; done_cyc = -1; rdy_err = 0; rst_hit = 0;
        test_reset();
        test_back_to_back();
        test_throttled();
        test_excess();
        test_start_busy();
        test_reset_mid();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bnn_weight_loader.md
BNN_WEIGHT_LOADER -- requirements
Module: bnn_weight_loader

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 12, number of weight bytes in one load frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, byte-buffer entries (power of two, minimum 2).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, begins a load frame when sampled high in IDLE.
REQ-006 SHALL have port s_valid, input, 1, weight byte valid.
REQ-007 SHALL have port s_ready, output, 1, loader accepts byte this cycle.
REQ-008 SHALL have port s_data, input, 8, weight byte; bit 0 pairs with input bit 0.
REQ-009 SHALL have port load_en, output, 1, nibble strobe to the BNN weight port.
REQ-010 SHALL have port nib_out, output, 4, weight nibble to the BNN weight port.
REQ-011 SHALL have port neuron_idx, output, 5, index of the neuron currently being written.
REQ-012 SHALL have port busy, output, 1, frame in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at frame completion.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, LOW, HIGH, DONE; all outputs registered or decoded from registered state.
REQ-015 IDLE: start=1 -> WAIT, clear accept and neuron counters; start while not IDLE SHALL be ignored.
REQ-016 s_ready SHALL be 1 only when state is not IDLE or DONE, FIFO is not full, and accepted-byte count < NUM_NEURONS.
REQ-017 A byte SHALL be accepted on a cycle with s_valid=1 and s_ready=1; bytes offered with s_ready=0 SHALL NOT be consumed.
REQ-018 WAIT with FIFO non-empty -> LOW; otherwise stay in WAIT.
REQ-019 LOW SHALL drive load_en=1 and nib_out=head[3:0], then always -> HIGH.
REQ-020 HIGH SHALL drive load_en=1 and nib_out=head[7:4], pop the FIFO, and increment neuron_idx.
REQ-021 From HIGH: if the popped byte is byte NUM_NEURONS-1 -> DONE; else if FIFO still non-empty -> LOW; else -> WAIT.
REQ-022 LOW and HIGH SHALL never be separated; load_en SHALL always assert in adjacent pairs, low nibble first.
REQ-023 Latency: byte accepted in cycle c into an empty FIFO while in WAIT -> LOW in cycle c+2, HIGH in cycle c+3.
REQ-024 Throughput with a continuously non-empty FIFO SHALL be one neuron per 2 cycles; a full frame takes at least 2*NUM_NEURONS cycles of load_en.
REQ-025 DONE SHALL assert done=1 for exactly one cycle, then -> IDLE.
REQ-026 busy SHALL be 1 in WAIT, LOW, HIGH, and DONE.
REQ-027 Outside LOW and HIGH: load_en=0 and nib_out=0.
REQ-028 Simultaneous push and pop on a full FIFO SHALL be legal only if s_ready was already 1; the FIFO SHALL never overflow or underflow.
REQ-029 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; the counters SHALL saturate at NUM_NEURONS and never wrap.

Reset
REQ-030 On reset: state=IDLE, FIFO empty, counters=0, load_en=0, nib_out=0, neuron_idx=0, busy=0, done=0, s_ready=0.
REQ-031 Reset mid-frame SHALL take priority over every other event, discard buffered bytes, and complete no partial nibble pair; the BNN shares this reset, so its nibble phase also clears.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the NUM_NEURONS default (12), and the nibble width (4).
REQ-033 The byte FIFO SHALL be a separate sub-module, bnn_byte_fifo (push, pop, full, empty, count).
REQ-034 Expected size is 150-300 lines of RTL.

Verification
REQ-035 Back-to-back stream: start, then 12 bytes with s_valid held high (0xA0, 0x41, ...). Required response: 24 consecutive load_en cycles; nibbles 0x0, 0xA, 0x1, 0x4, ...; done one cycle after the last HIGH.
REQ-036 Throttled source: 12 bytes, each offered every 5 cycles. Required response: each byte yields a LOW/HIGH pair in cycles c+2 and c+3; load_en=0 between pairs; neuron_idx ends at 12.
REQ-037 Excess bytes: s_valid held after the 12th byte. Required response: s_ready=0 after the 12th accept; the 13th byte is not consumed; done pulses once.
REQ-038 Start while busy: assert start in cycle 5 of a frame. Required response: no effect on counters or the nibble sequence.
REQ-039 Reset mid-frame: assert reset between a LOW and HIGH cycle on neuron 3. Required response: next cycle all outputs are 0, state is IDLE, FIFO is empty; a new start reloads from neuron 0.
REQ-040 Stalled source: after start, s_valid=0 for 50 cycles. Required response: the FSM stays in WAIT with busy=1, load_en=0, s_ready=1.
